// File: rtl/freq_meas_ctrl_if.sv
// Measurement pins in, published result words out, for the frequency-meter controller.
// master = controller side, slave = pin/SPI side.
interface freq_meas_ctrl_if #(
  parameter int CNT_W = 40
);
  logic             i_sig1;
  logic             i_sig2;
  logic             i_spi_cs;
  logic [CNT_W-1:0] o_tx_byte1;
  logic [CNT_W-1:0] o_tx_byte2;
  logic [7:0]       o_seq;
  logic             o_overrun;
  logic             o_gate;

  modport master (
    input  i_sig1, i_sig2, i_spi_cs,
    output o_tx_byte1, o_tx_byte2, o_seq, o_overrun, o_gate
  );

  modport slave (
    output i_sig1, i_sig2, i_spi_cs,
    input  o_tx_byte1, o_tx_byte2, o_seq, o_overrun, o_gate
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Two-channel edge counter over back-to-back gate windows; publishes both counts per window.
// Latency: pin edge -> counter 3 cycles; window end -> published words 3 cycles (cs idle).
// Backpressure: cs low holds the publish; a second capture while held overwrites and sets overrun.
module freq_meas_ctrl #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int          CNT_W       = 40
) (
  input  logic              i_clk,
  input  logic              i_rst,
  freq_meas_ctrl_if.master  bus
);

  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  typedef enum logic {PUB_IDLE, PUB_WAIT} pub_state_t;

  // Synchroniser / history flops are left unreset so a level held across reset
  // is never mistaken for a fresh edge.
  logic sig1_m_q, sig1_s_q, sig1_h_q, sig1_m_d, sig1_s_d, sig1_h_d;
  logic sig2_m_q, sig2_s_q, sig2_h_q, sig2_m_d, sig2_s_d, sig2_h_d;
  logic cs_m_q, cs_s_q, cs_m_d, cs_s_d;

  logic [31:0]      gate_cnt_q, gate_cnt_d;
  logic             gate_q, gate_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [CNT_W-1:0] pend1_q, pend1_d, pend2_q, pend2_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] tx1_q, tx1_d, tx2_q, tx2_d;
  logic [7:0]       seq_q, seq_d;
  logic             overrun_q, overrun_d;
  pub_state_t       state_q, state_d;

  logic             edge1, edge2, tc, publish;
  logic [CNT_W-1:0] cap1, cap2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  always_comb begin
    sig1_m_d = bus.i_sig1;
    sig1_s_d = sig1_m_q;
    sig1_h_d = sig1_s_q;
    sig2_m_d = bus.i_sig2;
    sig2_s_d = sig2_m_q;
    sig2_h_d = sig2_s_q;
    cs_m_d   = bus.i_spi_cs;
    cs_s_d   = cs_m_q;

    edge1 = sig1_s_q & ~sig1_h_q;
    edge2 = sig2_s_q & ~sig2_h_q;
    tc    = (gate_cnt_q == GATE_LAST);

    gate_cnt_d = tc ? 32'd0 : gate_cnt_q + 32'd1;
    gate_d     = (gate_cnt_d != GATE_LAST);

    // An edge seen in the terminal cycle still belongs to the closing window.
    cap1   = sat_inc(cnt1_q, edge1);
    cap2   = sat_inc(cnt2_q, edge2);
    cnt1_d = tc ? '0 : cap1;
    cnt2_d = tc ? '0 : cap2;

    publish = (state_q == PUB_WAIT) && cs_s_q;

    tx1_d = publish ? pend1_q : tx1_q;
    tx2_d = publish ? pend2_q : tx2_q;
    seq_d = publish ? seq_q + 8'd1 : seq_q;

    // A capture coinciding with a publish is not an overrun: the old pair leaves as the new one lands.
    pend1_d   = tc ? cap1 : pend1_q;
    pend2_d   = tc ? cap2 : pend2_q;
    pend_v_d  = tc | (pend_v_q & ~publish);
    overrun_d = overrun_q | (tc & pend_v_q & ~publish);

    state_d = state_q;
    case (state_q)
      PUB_IDLE: if (pend_v_q) state_d = PUB_WAIT;
      PUB_WAIT: if (publish && !tc) state_d = PUB_IDLE;
      default:  state_d = PUB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    sig1_m_q <= sig1_m_d;
    sig1_s_q <= sig1_s_d;
    sig1_h_q <= sig1_h_d;
    sig2_m_q <= sig2_m_d;
    sig2_s_q <= sig2_s_d;
    sig2_h_q <= sig2_h_d;
    cs_m_q   <= cs_m_d;
    cs_s_q   <= cs_s_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gate_cnt_q <= 32'd0;
      gate_q     <= 1'b1;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      pend1_q    <= '0;
      pend2_q    <= '0;
      pend_v_q   <= 1'b0;
      tx1_q      <= '0;
      tx2_q      <= '0;
      seq_q      <= 8'd0;
      overrun_q  <= 1'b0;
      state_q    <= PUB_IDLE;
    end else begin
      gate_cnt_q <= gate_cnt_d;
      gate_q     <= gate_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      pend_v_q   <= pend_v_d;
      tx1_q      <= tx1_d;
      tx2_q      <= tx2_d;
      seq_q      <= seq_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
    end
  end

  assign bus.o_tx_byte1 = tx1_q;
  assign bus.o_tx_byte2 = tx2_q;
  assign bus.o_seq      = seq_q;
  assign bus.o_overrun  = overrun_q;
  assign bus.o_gate     = gate_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl with a 100-cycle gate: directed scenarios plus a random soak,
// all outputs compared every cycle against a window/edge-counting reference model.
module tb_freq_meas_ctrl;
  localparam int GATE = 100;
  localparam int CW   = 40;
  localparam int MAXP = 4096;
  localparam logic [63:0] CMAX = (64'd1 << CW) - 64'd1;

  logic clk = 1'b0;
  logic rst;

  freq_meas_ctrl_if #(.CNT_W(CW)) bus();

  freq_meas_ctrl #(.GATE_CYCLES(GATE), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // p = number of rising clock edges so far; R = last edge that sampled reset high
  int p = 0;
  int R = 0;
  int mode = 0;
  bit cs_soak = 1'b1;
  bit pin1_at[MAXP];
  bit pin2_at[MAXP];
  bit cs_at[MAXP];
  bit rst_at[MAXP];

  logic [63:0] m_acc1, m_acc2, m_pend1, m_pend2, m_tx1, m_tx2;
  int m_seq, m_ready;
  bit m_pend_v, m_ovr, m_gate;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: an edge whose pin sample rises at edge k counts at edge k+2; window w owns the
  // counts landing on edges R+100w+1 .. R+100w+100 and is captured on the last of them.
  task automatic model_edge(input int q);
    bit pub, cap, e1, e2;
    if (rst_at[q]) begin
      R = q;
      m_acc1 = 0; m_acc2 = 0; m_pend1 = 0; m_pend2 = 0; m_pend_v = 0;
      m_tx1 = 0; m_tx2 = 0; m_seq = 0; m_ovr = 0; m_gate = 1;
      return;
    end
    e1 = (q >= 3) && pin1_at[q-2] && !pin1_at[q-3];
    e2 = (q >= 3) && pin2_at[q-2] && !pin2_at[q-3];
    if (e1 && m_acc1 < CMAX) m_acc1++;
    if (e2 && m_acc2 < CMAX) m_acc2++;
    pub = m_pend_v && (q >= m_ready) && (q >= 2) && cs_at[q-2];
    cap = ((q - R) % GATE) == 0;
    if (pub) begin
      m_tx1 = m_pend1;
      m_tx2 = m_pend2;
      m_seq = (m_seq + 1) % 256;
    end
    if (cap) begin
      if (m_pend_v && !pub) m_ovr = 1;
      m_ready  = m_pend_v ? q + 1 : q + 2;
      m_pend1  = m_acc1;
      m_pend2  = m_acc2;
      m_acc1   = 0;
      m_acc2   = 0;
      m_pend_v = 1;
    end else if (pub) begin
      m_pend_v = 0;
    end
    m_gate = ((q - R) % GATE) != GATE - 1;
  endtask

  task automatic apply_stim();
    int q, rel;
    bit per1, per2;
    q    = p + 1;
    rel  = q - R;
    per1 = (q % 10) < 5;
    per2 = (q % 4) < 2;
    case (mode)
      1: begin bus.i_sig1 = per1; bus.i_sig2 = per2; bus.i_spi_cs = 1'b1; end
      2: begin
        bus.i_sig1 = per1; bus.i_sig2 = per2;
        bus.i_spi_cs = rst || !(rel >= 90 && rel < 150);
      end
      3: begin
        bus.i_sig1 = !rst && ((rel < 100) ? ((rel % 10) < 5) : (rel < 200) ? (((rel - 100) % 20) < 10) : 1'b0);
        bus.i_sig2 = 1'b0;
        bus.i_spi_cs = rst || !(rel >= 50 && rel < 250);
      end
      4: begin
        bus.i_sig1 = !rst && (rel == 98 || rel == 99);
        bus.i_sig2 = 1'b0;
        bus.i_spi_cs = 1'b1;
      end
      5: begin
        if ($urandom_range(0, 39) == 0) cs_soak = ~cs_soak;
        bus.i_sig1 = 1'($urandom_range(0, 1));
        bus.i_sig2 = 1'($urandom_range(0, 1));
        bus.i_spi_cs = cs_soak;
      end
      default: begin
        bus.i_sig1 = 1'($urandom_range(0, 1));
        bus.i_sig2 = 1'($urandom_range(0, 1));
        bus.i_spi_cs = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  task automatic step();
    if (p + 1 >= MAXP) begin
      $display("FAIL cycle_budget edges=%0d limit=%0d", p, MAXP);
      $fatal(1, "cycle budget exhausted");
    end
    apply_stim();
    pin1_at[p+1] = bus.i_sig1;
    pin2_at[p+1] = bus.i_sig2;
    cs_at[p+1]   = bus.i_spi_cs;
    rst_at[p+1]  = rst;
    @(posedge clk);
    p++;
    model_edge(p);
    #1;
    check("tx1",     64'(bus.o_tx_byte1), m_tx1);
    check("tx2",     64'(bus.o_tx_byte2), m_tx2);
    check("seq",     64'(bus.o_seq),      64'(m_seq));
    check("overrun", 64'(bus.o_overrun),  64'(m_ovr));
    check("gate",    64'(bus.o_gate),     64'(m_gate));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;

    // Reset with random inputs, then time the first terminal cycle
    mode = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx1", 64'(bus.o_tx_byte1), 64'd0);
      check("rst_tx2", 64'(bus.o_tx_byte2), 64'd0);
      check("rst_seq", 64'(bus.o_seq), 64'd0);
      check("rst_ovr", 64'(bus.o_overrun), 64'd0);
      check("rst_gate", 64'(bus.o_gate), 64'd1);
    end
    rst = 1'b0;
    n = 1;
    while (bus.o_gate === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("gate_low_cycle", 64'(n), 64'd100);

    // Steady measurement, cs idle
    mode = 1;
    do_reset(3);
    for (int i = 0; i < 210; i++) begin
      step();
      if (p - R == 105) begin
        check("norm_w1_tx1", 64'(bus.o_tx_byte1), 64'd10);
        check("norm_w1_tx2", 64'(bus.o_tx_byte2), 64'd25);
        check("norm_w1_seq", 64'(bus.o_seq), 64'd1);
      end
      if (p - R == 205) begin
        check("norm_w2_tx1", 64'(bus.o_tx_byte1), 64'd10);
        check("norm_w2_tx2", 64'(bus.o_tx_byte2), 64'd25);
        check("norm_w2_seq", 64'(bus.o_seq), 64'd2);
      end
    end

    // Publish held off by cs low across the window end
    mode = 2;
    do_reset(3);
    for (int i = 0; i < 160; i++) begin
      step();
      if (p - R == 149) check("hold_seq_149", 64'(bus.o_seq), 64'd0);
      if (p - R == 151) check("hold_seq_151", 64'(bus.o_seq), 64'd0);
      if (p - R == 152) begin
        check("hold_seq_152", 64'(bus.o_seq), 64'd1);
        check("hold_tx1", 64'(bus.o_tx_byte1), 64'd10);
        check("hold_tx2", 64'(bus.o_tx_byte2), 64'd25);
        check("hold_ovr", 64'(bus.o_overrun), 64'd0);
      end
    end

    // Overrun: two window ends under cs low
    mode = 3;
    do_reset(3);
    for (int i = 0; i < 310; i++) begin
      step();
      if (p - R == 199) check("ovr_before", 64'(bus.o_overrun), 64'd0);
      if (p - R == 201) check("ovr_after", 64'(bus.o_overrun), 64'd1);
      if (p - R == 251) check("ovr_seq_251", 64'(bus.o_seq), 64'd0);
      if (p - R == 252) begin
        check("ovr_tx1", 64'(bus.o_tx_byte1), 64'd5);
        check("ovr_seq_252", 64'(bus.o_seq), 64'd1);
      end
      if (p - R == 306) begin
        check("ovr_w3_tx1", 64'(bus.o_tx_byte1), 64'd0);
        check("ovr_w3_seq", 64'(bus.o_seq), 64'd2);
        check("ovr_sticky", 64'(bus.o_overrun), 64'd1);
      end
    end

    // Edge landing in the terminal cycle
    mode = 4;
    do_reset(3);
    for (int i = 0; i < 210; i++) begin
      step();
      if (p - R == 105) check("bnd_w1_tx1", 64'(bus.o_tx_byte1), 64'd1);
      if (p - R == 205) begin
        check("bnd_w2_tx1", 64'(bus.o_tx_byte1), 64'd0);
        check("bnd_w2_seq", 64'(bus.o_seq), 64'd2);
      end
    end

    // Reset pulse at gate_cnt = 50 of the second window
    mode = 1;
    do_reset(3);
    while (p - R < 150) step();
    check("mid_pre_seq", 64'(bus.o_seq), 64'd1);
    do_reset(1);
    check("mid_rst_tx1", 64'(bus.o_tx_byte1), 64'd0);
    check("mid_rst_tx2", 64'(bus.o_tx_byte2), 64'd0);
    check("mid_rst_seq", 64'(bus.o_seq), 64'd0);
    for (int i = 0; i < 105; i++) begin
      step();
      if (p - R == 101) check("mid_no_stale", 64'(bus.o_seq), 64'd0);
      if (p - R == 105) begin
        check("mid_tx1", 64'(bus.o_tx_byte1), 64'd10);
        check("mid_tx2", 64'(bus.o_tx_byte2), 64'd25);
        check("mid_seq", 64'(bus.o_seq), 64'd1);
      end
    end

    // Random soak with cs bursts
    mode = 5;
    do_reset(3);
    repeat (700) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/freq_meas_ctrl.md
# freq_meas_ctrl

Gate-time scheduler and result publisher for the two-channel frequency meter. It counts rising edges of two input signals over back-to-back fixed gate windows on the system clock. At each window end it captures both counts and publishes them as the two 40-bit result words read out by the SPI slave. Publishing is deferred while SPI chip-select is asserted, so a readout never sees a word change mid-transfer.

## Interface
- GATE_CYCLES, 50_000_000, gate window length in i_clk cycles (1 s at 50 MHz); legal range 4 to 2^32-1.
- CNT_W, 40, edge-counter and result width.
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_sig1  in  1  channel-1 signal under measurement; asynchronous.
- i_sig2  in  1  channel-2 signal under measurement; asynchronous.
- i_spi_cs  in  1  SPI chip-select from the pin, active-low, asynchronous.
- o_tx_byte1  out  CNT_W  published channel-1 count; feeds SPI word 1.
- o_tx_byte2  out  CNT_W  published channel-2 count; feeds SPI word 2.
- o_seq  out  8  publish sequence number; wraps 255 -> 0.
- o_overrun  out  1  sticky flag; a captured window was discarded unpublished.
- o_gate  out  1  high except in the terminal cycle of each window.

## Operation
- Input synchronisers:
  - i_sig1 and i_sig2 each pass through a 2-FF synchroniser, then a history register. A rising edge is a synced 1 with history 0.
  - i_spi_cs passes through a 2-FF synchroniser to give cs_s.
- Gate counter:
  - Counts 0 .. GATE_CYCLES-1, then wraps to 0. Windows run back-to-back, with no dead cycle between them.
  - The terminal cycle (tc) is the cycle where gate_cnt == GATE_CYCLES-1. o_gate = 0 only in tc.
- Edge counters:
  - One per channel, CNT_W bits, incrementing on each detected edge.
  - Each saturates at 2^CNT_W-1 and does not wrap.
  - In tc, the counter's value plus that cycle's edge (if any) is captured. The counter is then reloaded with 0. An edge in tc therefore belongs to the closing window.
- Pending stage:
  - Capture loads pend1 and pend2 and sets pend_v.
  - If pend_v is already set at capture, the old pending pair is overwritten and o_overrun is set to 1.
  - o_overrun is cleared only by i_rst.
- Publish FSM, states PUB_IDLE and PUB_WAIT:
  - PUB_IDLE: if pend_v = 1, go to PUB_WAIT.
  - PUB_WAIT, cs_s = 1 (bus idle): copy pend1 and pend2 to o_tx_byte1 and o_tx_byte2, increment o_seq, clear pend_v, and return to PUB_IDLE.
  - PUB_WAIT, cs_s = 0: stay in PUB_WAIT and hold the outputs.
  - Capture and publish in the same cycle: the capture wins. pend_v stays 1, the new pair is kept, no overrun is flagged, and the old pair is published. The FSM stays in PUB_WAIT for the new pair.
- Outputs change only on a publish, and both words always change in the same cycle.

## Timing
- Reset: all counters are 0 and pend_v = 0. The FSM enters PUB_IDLE.
- Reset values of the outputs:
  - o_tx_byte1 = o_tx_byte2 = 0, o_seq = 0, o_overrun = 0.
  - o_gate = 1, since gate_cnt = 0.
- Reset mid-window discards partial counts and pending data. The first window after reset is exactly GATE_CYCLES cycles long, beginning in the cycle after i_rst goes low.
- Edge latency: a pin edge reaches its edge counter 3 cycles later.
- Publish latency, with tc at cycle t:
  - pend_v = 1 at t+1.
  - PUB_WAIT at t+2.
  - Outputs update at the edge ending t+2 if cs_s = 1, so they are visible at t+3.
- CS latency: a CS rising edge at the pin reaches cs_s 2 cycles later. Publish follows 1 cycle after that.
- Constraint: the signal frequency must be below f_clk/2; faster edges are undercounted. This is not detected.

## Test plan
All scenarios use GATE_CYCLES = 100.

- Reset with i_rst high for 3 cycles and random inputs:
  - All outputs hold their reset values.
  - o_gate first goes low 100 cycles after release.
- Normal measurement with i_spi_cs = 1:
  - Stimulus: i_sig1 with period 10, i_sig2 with period 4.
  - After the first window plus 3 cycles: o_tx_byte1 = 10, o_tx_byte2 = 25, o_seq = 1.
  - Every subsequent window gives the same values, with o_seq incrementing.
- Publish held off by CS:
  - Stimulus: i_spi_cs = 0 from cycle 90 to cycle 150.
  - Outputs stay unchanged through the window end.
  - The update occurs 3 cycles after the CS rise; o_overrun = 0.
- Overrun:
  - Stimulus: i_spi_cs = 0 across two window ends, with i_sig1 period 10 then period 20.
  - o_overrun = 1.
  - After CS rises, o_tx_byte1 = 5 and o_seq increments by exactly 1.
- Boundary edge:
  - Stimulus: a single i_sig1 pulse timed so its synced edge lands in tc.
  - That window's count is 1; the next window's count is 0.
- Reset mid-window:
  - Stimulus: i_rst pulsed at gate_cnt = 50.
  - Outputs return to 0 and pend_v clears.
  - The next capture occurs 100 cycles after release with full-window counts.
